axil_master_seq: RTL and testbench
==================================

// Module: axil_master_seq
// PURPOSE
//  Single-outstanding AXI4-Lite initiator. Turns one command (write or read) from a local
//  valid/ready port into a complete AXI4-Lite transaction and returns the response. Drives the
//  s00/s01 register slaves from PL-side sequencers and testbenches. No PS involvement.
// PARAMETERS
//  ADDR_WIDTH      5     AXI address width
//  DATA_WIDTH      32    AXI data width; WSTRB is DATA_WIDTH/8 bits, driven all-ones
//  TIMEOUT_CYCLES  255   cycles a transaction may wait before abort (timeout build only)
// PORTS
//  clk            in   1            single clock; all logic on posedge
//  rst            in   1            asynchronous, active-high reset
//  cmd_valid      in   1            command present
//  cmd_ready      out  1            high only in IDLE
//  cmd_write      in   1            1 = write, 0 = read
//  cmd_addr       in   ADDR_WIDTH   target address
//  cmd_wdata      in   DATA_WIDTH   write data (ignored for reads)
//  rsp_valid      out  1            response present; held until rsp_ready
//  rsp_ready      in   1            response consumed
//  rsp_rdata      out  DATA_WIDTH   read data (0 for writes)
//  rsp_resp       out  2            BRESP/RRESP, or 2'b11 on timeout
//  rsp_timeout    out  1            transaction aborted by timeout
//  m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master channels: awaddr awvalid awready wdata wstrb
//                 wvalid wready bresp bvalid bready araddr arvalid arready rdata rresp rvalid rready
// BEHAVIOUR
//  Reset (async): state=IDLE. All m_axi_*valid, bready, rready, rsp_valid, rsp_timeout = 0.
//   rsp_rdata, rsp_resp, awaddr, araddr, wdata = 0. cmd_ready = 1 (IDLE), also during reset.
//  States: IDLE, WADDR (AW/W outstanding), WRESP, RADDR, RDATA, RSP.
//  IDLE: cmd_valid&cmd_ready latches addr/wdata; next WADDR (write) or RADDR (read).
//  WADDR: awvalid and wvalid asserted the cycle after acceptance, each dropped independently
//   after its own handshake; payload stable while valid. bready = 1 here too.
//  WRESP: bready = 1. B is accepted on bvalid&bready only once both AW and W have handshaken,
//   counting handshakes in the same cycle (zero-latency responders tolerated).
//   Both complete + B accepted -> RSP with rsp_resp=bresp, rsp_rdata=0.
//  RADDR: arvalid asserted; rready = 1. R accepted in same cycle as AR handshake or later.
//  RDATA: rready = 1; on rvalid capture rdata/rresp -> RSP.
//  RSP: rsp_valid = 1; fields stable; rsp_valid&rsp_ready -> IDLE (cmd_ready high next cycle).
//  Min latency: cmd accept cycle 0 -> valids cycle 1 -> rsp_valid cycle 2 (zero-wait slave).
//  Single outstanding: no new command accepted until the response has been consumed.
//  SLVERR/DECERR passed through unchanged; no retry.
//  Reset mid-transaction: immediate return to IDLE, valids dropped; in-flight data discarded.
//  Unconsumed response (rsp_ready low): block holds in RSP indefinitely; AXI channels idle.
// CONFIGURATION
//  AXIL_MST_TIMEOUT_EN defined: 8-bit+ counter clears on command acceptance, increments each
//   cycle in WADDR/WRESP/RADDR/RDATA; at TIMEOUT_CYCLES all valids/readies drop, -> RSP with
//   rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0. Late B/R are ignored (readies low).
//  Not defined: no counter; waits forever; rsp_timeout tied 0.
// TESTING
//  1 Write addr 5'h00 data 32'h00ABCDEF, always-ready BFM with same-cycle B -> one AW/W
//    handshake, rsp_valid at cycle 2, rsp_resp=2'b00, rsp_rdata=0.
//  2 Read 5'h00 after test 1, BFM returns stored word -> rsp_rdata=32'h00ABCDEF, resp=00.
//  3 BFM: awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid
//    held 4 cycles with constant awaddr, one B accepted, single response.
//  4 BFM rresp=2'b10 on read 5'h14 -> rsp_resp=2'b10, rsp_timeout=0.
//  5 rsp_ready low 10 cycles -> rsp_valid/fields stable, cmd_ready low, no new AXI traffic.
//  6 (AXIL_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16) arready stuck 0 -> arvalid drops after 16
//    cycles, rsp_resp=2'b11, rsp_timeout=1; then assert rst in WADDR -> all valids 0 at once.

Source files
------------

// File: rtl/axil_master_seq.sv
// Single-outstanding AXI4-Lite initiator: one local command in, one AXI transaction, one response out.
// Optional abort counter enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_master_seq #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StRsp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    tmo_flag_q, tmo_flag_d;
    logic                    tmo_hit;
    logic                    cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                    aw_all, w_all;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy;

    assign busy    = (state_q == StWaddr) || (state_q == StWresp) ||
                     (state_q == StRaddr) || (state_q == StRdata);
    assign tmo_hit = busy && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (cmd_fire) begin
            cnt_d = '0;
        end else if (busy && !tmo_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Valids/readies are gated by tmo_hit so an aborted channel cannot complete a handshake.
    always_comb begin
        cmd_ready     = (state_q == StIdle);
        rsp_valid     = (state_q == StRsp);
        m_axi_awvalid = (state_q == StWaddr) && !aw_done_q && !tmo_hit;
        m_axi_wvalid  = (state_q == StWaddr) && !w_done_q && !tmo_hit;
        m_axi_bready  = ((state_q == StWaddr) || (state_q == StWresp)) && !tmo_hit;
        m_axi_arvalid = (state_q == StRaddr) && !tmo_hit;
        m_axi_rready  = ((state_q == StRaddr) || (state_q == StRdata)) && !tmo_hit;
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = '1;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign rsp_timeout  = tmo_flag_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign aw_fire  = m_axi_awvalid && m_axi_awready;
    assign w_fire   = m_axi_wvalid && m_axi_wready;
    assign b_fire   = m_axi_bvalid && m_axi_bready;
    assign ar_fire  = m_axi_arvalid && m_axi_arready;
    assign r_fire   = m_axi_rvalid && m_axi_rready;
    assign aw_all   = aw_done_q || aw_fire;
    assign w_all    = w_done_q || w_fire;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        tmo_flag_d = tmo_flag_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    tmo_flag_d = 1'b0;
                    state_d    = cmd_write ? StWaddr : StRaddr;
                end
            end
            StWaddr, StWresp: begin
                aw_done_d = aw_all;
                w_done_d  = w_all;
                if (tmo_hit) begin
                    resp_d     = 2'b11;
                    rdata_d    = '0;
                    tmo_flag_d = 1'b1;
                    state_d    = StRsp;
                end else if (aw_all && w_all) begin
                    // B only counts once both AW and W are done, same-cycle included.
                    if (b_fire) begin
                        resp_d  = m_axi_bresp;
                        rdata_d = '0;
                        state_d = StRsp;
                    end else begin
                        state_d = StWresp;
                    end
                end
            end
            StRaddr: begin
                if (tmo_hit) begin
                    resp_d     = 2'b11;
                    rdata_d    = '0;
                    tmo_flag_d = 1'b1;
                    state_d    = StRsp;
                end else if (ar_fire) begin
                    if (r_fire) begin
                        resp_d  = m_axi_rresp;
                        rdata_d = m_axi_rdata;
                        state_d = StRsp;
                    end else begin
                        state_d = StRdata;
                    end
                end
            end
            StRdata: begin
                if (tmo_hit) begin
                    resp_d     = 2'b11;
                    rdata_d    = '0;
                    tmo_flag_d = 1'b1;
                    state_d    = StRsp;
                end else if (r_fire) begin
                    resp_d  = m_axi_rresp;
                    rdata_d = m_axi_rdata;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

endmodule

// File: tb/tb_axil_master_seq.sv
// Directed bench for axil_master_seq with a small configurable AXI4-Lite slave model.
// Timeout steps run only when AXIL_MST_TIMEOUT_EN is defined.
module tb_axil_master_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [4:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    int n_asserts = 0;
    int n_fail    = 0;

    axil_master_seq #(
        .ADDR_WIDTH     (5),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    // Slave model knobs, written only by the stimulus block.
    int         aw_lat    = 0;
    int         w_lat     = 0;
    logic       ar_stuck  = 1'b0;
    logic [1:0] rresp_cfg = 2'b00;
    logic [4:0] aw_expect = '0;

    // Slave model state and event counters, written only by the model.
    logic [31:0] mem [8];
    logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
    logic [4:0]  aw_addr_l = '0, ar_addr_l = '0;
    logic [31:0] w_data_l = '0;
    int aw_cnt = 0, w_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_cnt = 0, r_cnt = 0;
    int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, traffic = 0, awaddr_bad = 0;

    logic aw_fire, w_fire, ar_fire;
    logic [4:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_lat);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_lat);
    assign aw_fire       = m_axi_awvalid && m_axi_awready;
    assign w_fire        = m_axi_wvalid && m_axi_wready;
    assign m_axi_bvalid  = (aw_got || aw_fire) && (w_got || w_fire);
    assign m_axi_bresp   = 2'b00;
    assign wr_addr       = aw_fire ? m_axi_awaddr : aw_addr_l;
    assign wr_data       = w_fire ? m_axi_wdata : w_data_l;
    assign m_axi_arready = m_axi_arvalid && !ar_stuck;
    assign ar_fire       = m_axi_arvalid && m_axi_arready;
    assign m_axi_rvalid  = ar_fire || r_pend;
    assign rd_addr       = ar_fire ? m_axi_araddr : ar_addr_l;
    assign m_axi_rdata   = mem[rd_addr[4:2]];
    assign m_axi_rresp   = rresp_cfg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            r_pend <= 1'b0;
            aw_cnt <= 0;
            w_cnt  <= 0;
        end else begin
            if (m_axi_awvalid) awv_cyc <= awv_cyc + 1;
            if (m_axi_wvalid)  wv_cyc  <= wv_cyc + 1;
            if (m_axi_arvalid) arv_cyc <= arv_cyc + 1;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) traffic <= traffic + 1;
            if (m_axi_awvalid && m_axi_awaddr != aw_expect) awaddr_bad <= awaddr_bad + 1;
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            if (m_axi_wvalid && !m_axi_wready)   w_cnt  <= w_cnt + 1;
            if (aw_fire) begin
                aw_cnt    <= 0;
                aw_got    <= 1'b1;
                aw_addr_l <= m_axi_awaddr;
                aw_hs     <= aw_hs + 1;
            end
            if (w_fire) begin
                w_cnt    <= 0;
                w_got    <= 1'b1;
                w_data_l <= m_axi_wdata;
                w_hs     <= w_hs + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                mem[wr_addr[4:2]] <= wr_data;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_cnt  <= b_cnt + 1;
            end
            if (ar_fire) ar_addr_l <= m_axi_araddr;
            if (m_axi_rvalid && m_axi_rready) begin
                r_pend <= 1'b0;
                r_cnt  <= r_cnt + 1;
            end else if (ar_fire) begin
                r_pend <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge (cycle 1).
    task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d);
        chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_arrived", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_consume", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_after_consume", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int b0, aw0, w0, awv0, wv0, tr0, arv0, bad0, r0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                           m_axi_bready, m_axi_rready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        chk("rst_awaddr", {27'd0, m_axi_awaddr}, 32'd0);
        chk("rst_wdata", m_axi_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait write
        b0 = b_cnt; aw0 = aw_hs; w0 = w_hs;
        aw_expect = 5'h00;
        send(1'b1, 5'h00, 32'h00AB_CDEF);
        chk("t1_awvalid_c1", {31'd0, m_axi_awvalid}, 32'd1);
        chk("t1_wvalid_c1", {31'd0, m_axi_wvalid}, 32'd1);
        chk("t1_bready_c1", {31'd0, m_axi_bready}, 32'd1);
        chk("t1_wdata", m_axi_wdata, 32'h00AB_CDEF);
        chk("t1_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
        chk("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        wait_rsp(20, n);
        chk("t1_latency", n, 32'd1);
        chk("t1_resp", {30'd0, rsp_resp}, 32'd0);
        chk("t1_rdata", rsp_rdata, 32'd0);
        chk("t1_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("t1_aw_hs", aw_hs - aw0, 32'd1);
        chk("t1_w_hs", w_hs - w0, 32'd1);
        chk("t1_b_cnt", b_cnt - b0, 32'd1);
        consume();

        // 2: read back
        send(1'b0, 5'h00, 32'd0);
        chk("t2_arvalid_c1", {31'd0, m_axi_arvalid}, 32'd1);
        chk("t2_araddr", {27'd0, m_axi_araddr}, 32'd0);
        wait_rsp(20, n);
        chk("t2_latency", n, 32'd1);
        chk("t2_rdata", rsp_rdata, 32'h00AB_CDEF);
        chk("t2_resp", {30'd0, rsp_resp}, 32'd0);
        consume();

        // 3: AW ready 3 cycles late, W immediate
        aw_lat = 3;
        aw_expect = 5'h0C;
        b0 = b_cnt; aw0 = aw_hs; awv0 = awv_cyc; wv0 = wv_cyc; bad0 = awaddr_bad;
        send(1'b1, 5'h0C, 32'hCAFE_F00D);
        wait_rsp(20, n);
        chk("t3_latency", n, 32'd4);
        chk("t3_awvalid_cycles", awv_cyc - awv0, 32'd4);
        chk("t3_wvalid_cycles", wv_cyc - wv0, 32'd1);
        chk("t3_aw_hs", aw_hs - aw0, 32'd1);
        chk("t3_b_cnt", b_cnt - b0, 32'd1);
        chk("t3_awaddr_stable", awaddr_bad - bad0, 32'd0);
        chk("t3_resp", {30'd0, rsp_resp}, 32'd0);
        consume();
        aw_lat = 0;
        chk("t3_single_b", b_cnt - b0, 32'd1);

        // 4: SLVERR on read passes through
        rresp_cfg = 2'b10;
        r0 = r_cnt;
        send(1'b0, 5'h14, 32'd0);
        wait_rsp(20, n);
        chk("t4_resp", {30'd0, rsp_resp}, 32'h2);
        chk("t4_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("t4_r_cnt", r_cnt - r0, 32'd1);
        consume();
        rresp_cfg = 2'b00;

        // 5: response held unconsumed with a competing command pending
        aw_expect = 5'h08;
        send(1'b1, 5'h08, 32'h1234_5678);
        wait_rsp(20, n);
        tr0 = traffic;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("t5_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("t5_resp_stable", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
            chk("t5_rdata_stable", rsp_rdata, 32'd0);
        end
        cmd_valid = 1'b0;
        chk("t5_no_traffic", traffic - tr0, 32'd0);
        consume();
        send(1'b0, 5'h08, 32'd0);
        wait_rsp(20, n);
        chk("t5_readback", rsp_rdata, 32'h1234_5678);
        consume();

`ifdef AXIL_MST_TIMEOUT_EN
        // 6a: AR never accepted -> abort after 16 cycles
        ar_stuck = 1'b1;
        arv0 = arv_cyc;
        send(1'b0, 5'h04, 32'd0);
        wait_rsp(40, n);
        chk("t6_latency", n, 32'd17);
        chk("t6_arvalid_cycles", arv_cyc - arv0, 32'd16);
        chk("t6_resp", {30'd0, rsp_resp}, 32'h3);
        chk("t6_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("t6_rdata", rsp_rdata, 32'd0);
        chk("t6_arvalid_dropped", {31'd0, m_axi_arvalid}, 32'd0);
        consume();
        ar_stuck = 1'b0;
`endif

        // 6b: reset asserted while in WADDR
        aw_lat = 5;
        aw_expect = 5'h10;
        send(1'b1, 5'h10, 32'hDEAD_BEEF);
        chk("t6_awvalid_pre_rst", {31'd0, m_axi_awvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_valids_rst", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                              m_axi_bready, m_axi_rready}, 32'd0);
        chk("t6_rsp_valid_rst", {31'd0, rsp_valid}, 32'd0);
        chk("t6_cmd_ready_rst", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        aw_lat = 0;
        @(negedge clk);
        send(1'b0, 5'h00, 32'd0);
        wait_rsp(20, n);
        chk("t6_post_rst_latency", n, 32'd1);
        chk("t6_post_rst_rdata", rsp_rdata, 32'h00AB_CDEF);
        chk("t6_post_rst_timeout", {31'd0, rsp_timeout}, 32'd0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
